// File: rtl/rdout_pkg.sv
// Shared types and default constants for the CIM macro readout controller.
// Optional output ReLU clamp is enabled by defining RDOUT_RELU_EN.
package rdout_pkg;
  localparam int N_COL   = 64;
  localparam int MAC_DW  = 6;
  localparam int N_PHASE = 4;
  localparam int ADC_LAT = 2;
  localparam int ACC_DW  = MAC_DW + N_PHASE;

  typedef enum logic [2:0] {IDLE, SET, CONV, WAIT, SAMPLE, DONE} state_e;

  typedef logic signed [MAC_DW-1:0] mac_word_t;
  typedef logic signed [ACC_DW-1:0] acc_word_t;
endpackage

// File: rtl/rdout_acc_col.sv
// One macro column: signed shift-accumulate of the per-phase ADC word.
// The sign plane subtracts its term so the sum is a two's-complement dot product.
module rdout_acc_col #(
  parameter int MAC_DW = 6,
  parameter int ACC_DW = 10,
  parameter int PW     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic                     neg_i,
  input  logic [PW-1:0]            phase_i,
  input  logic signed [MAC_DW-1:0] din_i,
  output logic signed [ACC_DW-1:0] acc_o
);
  logic signed [ACC_DW-1:0] acc_q, acc_d, term;

  always_comb begin
    term  = ACC_DW'(din_i) <<< phase_i;
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = neg_i ? acc_q - term : acc_q + term;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/macro_rdout.sv
// Sequencer and readout for one CIM macro: steps through bit-plane phases,
// accumulates column outputs, and hands the sums downstream (RDOUT_RELU_EN clamps negatives).
module macro_rdout #(
  parameter int MAC_DW  = rdout_pkg::MAC_DW,
  parameter int N_COL   = rdout_pkg::N_COL,
  parameter int N_PHASE = rdout_pkg::N_PHASE,
  parameter int ADC_LAT = rdout_pkg::ADC_LAT,
  parameter int ACC_DW  = MAC_DW + N_PHASE
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 mac_enable,
  output logic [1:0]                           mac_chs_ps,
  output logic                                 mac_adc,
  input  logic signed [N_COL-1:0][MAC_DW-1:0]  mac_dout,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic signed [N_COL-1:0][ACC_DW-1:0]  res_data
);
  import rdout_pkg::*;

  localparam int PW = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;
  localparam int WW = (ADC_LAT > 1) ? $clog2(ADC_LAT) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(N_PHASE - 1);
  localparam logic [WW-1:0] W_LAST = WW'(ADC_LAT - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   p_q, p_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic            acc_clr, acc_en, acc_neg;
  logic [N_COL-1:0][ACC_DW-1:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE:   if (start) begin state_d = SET; p_d = '0; end
      SET:    state_d = CONV;
      CONV:   begin state_d = WAIT; wcnt_d = '0; end
      WAIT:   begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == W_LAST) state_d = SAMPLE;
      end
      SAMPLE: if (p_q == P_LAST) state_d = DONE;
              else begin state_d = SET; p_d = p_q + 1'b1; end
      DONE:   if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    mac_enable = (state_q == SET) || (state_q == CONV) ||
                 (state_q == WAIT) || (state_q == SAMPLE);
    mac_chs_ps = mac_enable ? 2'(p_q) : 2'b00;
    mac_adc    = (state_q == CONV);
    res_valid  = (state_q == DONE);
  end

  assign acc_clr = (state_q == IDLE) && start;
  assign acc_en  = (state_q == SAMPLE);
  assign acc_neg = (p_q == P_LAST);

  for (genvar c = 0; c < N_COL; c++) begin : g_col
    rdout_acc_col #(.MAC_DW(MAC_DW), .ACC_DW(ACC_DW), .PW(PW)) u_col (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (acc_clr),
      .en_i    (acc_en),
      .neg_i   (acc_neg),
      .phase_i (p_q),
      .din_i   (mac_dout[c]),
      .acc_o   (acc[c])
    );
`ifdef RDOUT_RELU_EN
    assign res_data[c] = acc[c][ACC_DW-1] ? '0 : acc[c];
`else
    assign res_data[c] = acc[c];
`endif
  end
endmodule

// File: tb/tb_macro_rdout.sv
// Directed bench for macro_rdout with a scoreboard of expected tile results.
module tb_macro_rdout;
  import rdout_pkg::*;

  localparam int DW = N_COL * ACC_DW;
  typedef logic [N_COL-1:0][ACC_DW-1:0] res_t;

  logic clk = 1'b0, rst_n, start, res_ready;
  logic busy, mac_enable, mac_adc, res_valid;
  logic [1:0] mac_chs_ps;
  logic signed [N_COL-1:0][MAC_DW-1:0] mac_dout;
  logic signed [N_COL-1:0][ACC_DW-1:0] res_data;

  logic [N_COL-1:0][MAC_DW-1:0] tbl [N_PHASE];
  logic [N_COL-1:0][MAC_DW-1:0] junk;
  res_t sb[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign mac_dout = mac_enable ? tbl[mac_chs_ps] : junk;

  macro_rdout dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .mac_enable(mac_enable), .mac_chs_ps(mac_chs_ps), .mac_adc(mac_adc),
    .mac_dout(mac_dout), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model();
    res_t r;
    for (int c = 0; c < N_COL; c++) begin
      int s = 0;
      for (int p = 0; p < N_PHASE; p++) begin
        int v = $signed(tbl[p][c]);
        if (p == N_PHASE - 1) s -= v * (1 << p);
        else                  s += v * (1 << p);
      end
`ifdef RDOUT_RELU_EN
      if (s < 0) s = 0;
`endif
      r[c] = s[ACC_DW-1:0];
    end
    return r;
  endfunction

  task automatic fill(input int p, input logic [MAC_DW-1:0] v);
    for (int c = 0; c < N_COL; c++) tbl[p][c] = v;
  endtask

  task automatic launch();
    sb.push_back(model());
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int lat = 0, adcs = 0;
    while (!res_valid && lat < 200) begin
      if (mac_adc) adcs++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, N_PHASE * (3 + ADC_LAT));
    chk({tag, "_adcs"}, adcs, N_PHASE);
    chk({tag, "_busy_done"}, busy, 1'b1);
    chk({tag, "_en_done"}, mac_enable, 1'b0);
  endtask

  task automatic take(input string tag);
    res_t e = sb.size() ? sb.pop_front() : '0;
    chk({tag, "_data"}, res_data, e);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_busy_after"}, busy, 1'b0);
    chk({tag, "_valid_after"}, res_valid, 1'b0);
  endtask

  initial begin
    logic [ACC_DW-1:0] ec;
    res_t cap;
    int n, to;

    rst_n = 1'b0; start = 1'b0; res_ready = 1'b0;
    junk = {N_COL{6'h2A}};
    for (int p = 0; p < N_PHASE; p++) fill(p, '0);
    repeat (3) @(negedge clk);
    chk("rst_outs", {busy, mac_enable, mac_chs_ps, mac_adc, res_valid}, '0);
    chk("rst_data", res_data, '0);
    rst_n = 1'b1;

    n = 0;
    res_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n += int'(mac_adc) + int'(busy) + int'(res_valid) + int'(mac_enable);
    end
    res_ready = 1'b0;
    chk("idle_quiet", n, 0);

    // all-ones: 1+2+4-8 = -1
    for (int p = 0; p < N_PHASE; p++) fill(p, 6'd1);
    launch();
    wait_valid("t1");
`ifdef RDOUT_RELU_EN
    ec = '0;
`else
    ec = '1;
`endif
    chk("t1_c0", res_data[0], ec);
    take("t1");

    // 3s in low planes, sign plane 0 except column 5 = -32
    for (int p = 0; p < N_PHASE - 1; p++) fill(p, 6'd3);
    fill(N_PHASE - 1, 6'd0);
    tbl[N_PHASE-1][5] = 6'b100000;
    launch();
    wait_valid("t2");
    ec = 10'd277;
    chk("t2_c5", res_data[5], ec);
    ec = 10'd21;
    chk("t2_c6", res_data[6], ec);

    // hold off ready, with ignored starts during DONE and at the handshake
    cap = res_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i == 4);
      chk("hold_stable", res_data, cap);
      chk("hold_valid", res_valid, 1'b1);
    end
    start = 1'b1;
    take("t2");
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      n += int'(busy) + int'(res_valid);
    end
    chk("no_second_tile", n, 0);

    // reset during WAIT of phase 2 aborts the tile
    for (int p = 0; p < N_PHASE; p++) fill(p, 6'd5);
    launch();
    to = 0;
    while (!(mac_adc && mac_chs_ps == 2'd2) && to < 200) begin
      @(negedge clk);
      to++;
    end
    chk("reach_p2_conv", to < 200, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    void'(sb.pop_front());
    #1;
    chk("abort_outs", {busy, mac_enable, mac_chs_ps, mac_adc, res_valid}, '0);
    chk("abort_data", res_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_idle", {busy, res_valid}, '0);

    // fresh tile after abort: 2*(1+2+4-8) = -2
    for (int p = 0; p < N_PHASE; p++) fill(p, 6'd2);
    launch();
    wait_valid("t3");
`ifdef RDOUT_RELU_EN
    ec = '0;
`else
    ec = 10'h3FE;
`endif
    chk("t3_c63", res_data[63], ec);
    take("t3");

    // phase 0 only: result 1 regardless of clamp
    fill(0, 6'd1);
    for (int p = 1; p < N_PHASE; p++) fill(p, 6'd0);
    launch();
    wait_valid("t4");
    ec = 10'd1;
    chk("t4_c10", res_data[10], ec);
    take("t4");

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/macro_rdout.md
Name: macro_rdout

Overview:
- Controller and readout for one CIM compute macro.
- Sequences the macro's control inputs (enable, chs_ps, adc) over N_PHASE input bit-plane phases.
- Samples the macro's 64 signed column outputs after each ADC conversion and shift-accumulates them into 64 signed partial sums.
- Presents the sums downstream with a valid/ready handshake. Sits between the macro and the layer's partial-sum adder tree.

Parameters:
- MAC_DW, 6: width of each macro column output; must equal `MACRO_O_DW from defines.v.
- N_COL, 64: number of macro output columns.
- N_PHASE, 4: input bit-plane phases per tile, LSB first; the last phase is the sign (MSB) plane.
- ADC_LAT, 2: cycles from the adc pulse until macro outputs are stable (≥1).
- ACC_DW, 10: accumulator width; must equal MAC_DW+N_PHASE.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to process one tile
- busy  out  1  high from start acceptance until the result is accepted
- mac_enable  out  1  to macro enable
- mac_chs_ps  out  2  to macro chs_ps; current phase index
- mac_adc  out  1  to macro adc; one-cycle conversion pulse
- mac_dout  in  N_COL×MAC_DW signed  from macro data_out
- res_valid  out  1  result valid
- res_ready  in  1  downstream accept
- res_data  out  N_COL×ACC_DW signed  accumulated column sums

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous and active-low.
  - All outputs, accumulators, phase counter and wait counter go to 0; FSM goes to IDLE.
  - Reset mid-tile aborts the tile; no partial result is ever emitted.
- FSM states: IDLE → SET → CONV → WAIT → SAMPLE → (SET or DONE) → IDLE.
- IDLE:
  - busy=0.
  - start=1 clears accumulators and the phase counter p, then goes to SET.
- SET: mac_enable=1, mac_chs_ps=p; lasts 1 cycle.
- CONV: mac_adc=1 for exactly 1 cycle; mac_enable and mac_chs_ps are held.
- WAIT: lasts ADC_LAT cycles, counted by the wait counter.
- SAMPLE: for each column c, acc[c] updates from the sign-extended mac_dout[c] shifted left by p.
  - p<N_PHASE-1: acc[c] += that value.
  - p=N_PHASE-1: acc[c] -= that value (two's-complement sign plane).
  - If p<N_PHASE-1: p++ and go to SET. Otherwise go to DONE.
- mac_enable stays high from SET of phase 0 through SAMPLE of the last phase, then drops to 0 in DONE.
- DONE:
  - res_valid=1; res_data holds acc and is stable while res_valid=1.
  - Leaves to IDLE on the cycle where res_valid&&res_ready.
- Latency: res_valid rises N_PHASE×(3+ADC_LAT) cycles after the start-accept edge. Defaults give 20 cycles.
- Boundaries:
  - start while busy=1 (including in DONE) is ignored.
  - start on the same cycle as the DONE handshake is ignored.
  - res_ready outside DONE has no effect.
  - No accumulator overflow is possible by the width rule ACC_DW=MAC_DW+N_PHASE.
  - mac_dout is sampled only in SAMPLE; it is don't-care at all other times.

Optional Feature:
- Macro: RDOUT_RELU_EN.
- Defined: res_data[c] = 0 when acc[c] is negative, else acc[c]. The clamp is combinational on the output; acc itself is unchanged.
- Undefined: res_data = acc unmodified.

Decomposition:
- Shared package rdout_pkg holds:
  - typedef for the state enum: IDLE, SET, CONV, WAIT, SAMPLE, DONE.
  - constants N_COL, MAC_DW, ACC_DW.
  - typedefs mac_word_t and acc_word_t.
- One natural sub-module, rdout_acc_col: a single-column signed shift-accumulator with clear, enable, phase and negate inputs. It is instantiated N_COL times by a generate loop. The FSM stays in macro_rdout.

Test Plan:
- Reset then idle, start held 0: all outputs 0; busy=0; mac_adc never pulses.
- mac_dout=1 on all columns every phase, defaults: res_valid at cycle 20; res_data = 1+2+4−8 = −1 on every column.
- mac_dout=3 in phases 0–2, 0 in phase 3, column 5 = −32 in phase 3: col 5 = 21+256 = 277; others = 21.
- res_ready held 0 for 10 cycles after res_valid, then 1:
  - res_data is stable throughout.
  - busy drops the cycle after the handshake.
  - a start pulse during the hold is ignored (no second tile).
- rst_n asserted during WAIT of phase 2, released, then new start with mac_dout=2 all phases: result = 2×(1+2+4−8) = −2; no stale accumulation.
- With RDOUT_RELU_EN and the all-1 stimulus: res_data = 0 on every column. With mac_dout=1 in phase 0 only: res_data = 1.
